// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI mode-0 register bank with write/read frames, commit strobe and error counter.
// All SPI pins are oversampled in the clk domain; frame logic runs on detected pin edges.
module spi_regfile #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sCLK,
  input  logic                       nCS,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_count
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0]  C_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  C_FRAME = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0]  C_OVR   = CNT_W'(FRAME + 1);
  localparam logic [ADDR_W:0]   C_NREGS = (ADDR_W + 1)'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
  logic sclk_hist, ncs_hist;
  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  // nCS chain resets low so a frame already in progress at reset release is never seen as starting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ncs_sync  <= '0;
      copi_sync <= '0;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sCLK};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
      sclk_hist <= sclk_s;
      ncs_hist  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;

  logic              active;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              rw, rw_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] data, data_n;
  logic [DATA_W-1:0] rd_sh, rd_val;
  logic              cipo_q;
  logic              shift_en, addr_ok, commit, reject, load_rd, shift_out;

  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       pend;
  logic [ADDR_W-1:0]          pend_addr;
  logic [DATA_W-1:0]          pend_data;

  // An sCLK edge coinciding with the closing nCS edge still counts toward the frame
  assign shift_en = active & sclk_rise & (~ncs_s | ncs_rise);

  always_comb begin
    cnt_n  = cnt;
    rw_n   = rw;
    addr_n = addr;
    data_n = data;
    if (shift_en) begin
      if (cnt == '0)
        rw_n = copi_s;
      else if (cnt <= C_ADDR)
        addr_n = ADDR_W'({addr, copi_s});
      else if (cnt < C_FRAME)
        data_n = DATA_W'({data, copi_s});
      if (cnt != C_OVR)
        cnt_n = cnt + 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (addr_n == ADDR_W'(r))
        rd_val = regs_q[r*DATA_W +: DATA_W];
  end

  assign addr_ok   = {1'b0, addr_n} < C_NREGS;
  assign commit    = active & ncs_rise & (cnt_n == C_FRAME) & rw_n & addr_ok;
  assign reject    = active & ncs_rise & ~((cnt_n == C_FRAME) & (~rw_n | addr_ok));
  assign load_rd   = shift_en & (cnt == C_ADDR) & ~rw;
  assign shift_out = active & sclk_fall & ~ncs_s & ~rw & (cnt > C_ADDR) & (cnt < C_FRAME);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      rw     <= 1'b0;
      addr   <= '0;
      data   <= '0;
      rd_sh  <= '0;
      cipo_q <= 1'b0;
    end else if (ncs_fall) begin
      active <= 1'b1;
      cnt    <= '0;
      rw     <= 1'b0;
      addr   <= '0;
      data   <= '0;
      rd_sh  <= '0;
      cipo_q <= 1'b0;
    end else if (active) begin
      cnt  <= cnt_n;
      rw   <= rw_n;
      addr <= addr_n;
      data <= data_n;
      if (load_rd)
        rd_sh <= rd_val;
      else if (shift_out) begin
        cipo_q <= rd_sh[DATA_W-1];
        rd_sh  <= DATA_W'({rd_sh, 1'b0});
      end
      if (ncs_rise) begin
        active <= 1'b0;
        cnt    <= '0;
        cipo_q <= 1'b0;
      end
    end else begin
      cipo_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      regs_q    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err_count <= '0;
    end else begin
      pend      <= commit;
      wr_strobe <= pend;
      if (commit) begin
        pend_addr <= addr_n;
        pend_data <= data_n;
      end
      if (pend) begin
        wr_addr <= pend_addr;
        for (int r = 0; r < NUM_REGS; r++)
          if (pend_addr == ADDR_W'(r))
            regs_q[r*DATA_W +: DATA_W] <= pend_data;
      end
      if (reject && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  assign regs_out = regs_q;
  assign CIPO     = cipo_q;

endmodule

// File: tb/tb_spi_regfile.sv
// tb/tb_spi_regfile.sv - randomized SPI frame bench for spi_regfile against an array-based register model.
module tb_spi_regfile;
  logic        clk = 1'b0;
  logic        rst, sCLK, nCS, COPI;
  logic        CIPO;
  logic [39:0] regs_out;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [7:0]  err_count;

  spi_regfile dut (
    .clk(clk), .rst(rst), .sCLK(sCLK), .nCS(nCS), .COPI(COPI),
    .CIPO(CIPO), .regs_out(regs_out), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] mregs [5];
  int merr = 0;
  int strobe_hi = 0;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_hi++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] flat();
    logic [39:0] f;
    for (int r = 0; r < 5; r++) f[r*8 +: 8] = mregs[r];
    return f;
  endfunction

  task automatic send_bit(input logic b, input int idx, inout logic [7:0] rd);
    COPI = b;
    repeat (8) @(posedge clk);
    sCLK = 1'b1;
    repeat (4) @(negedge clk);
    if (idx >= 8 && idx < 16) rd[15-idx] = CIPO;
    repeat (4) @(posedge clk);
    sCLK = 1'b0;
  endtask

  // Full frame; nbits != 16 gives short or overrun frames
  task automatic frame(input logic rw, input logic [6:0] a, input logic [7:0] d, input int nbits);
    logic [15:0] w;
    logic [7:0]  rd;
    logic [7:0]  exp_rd;
    int          s0;
    bit          full, wr_ok;
    w = {rw, a, d};
    rd = 8'h00;
    s0 = strobe_hi;
    @(posedge clk);
    nCS = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < nbits; i++)
      send_bit((i < 16) ? w[15-i] : 1'($urandom), i, rd);
    repeat (8) @(posedge clk);
    nCS = 1'b1;
    repeat (12) @(posedge clk);
    full  = (nbits == 16);
    wr_ok = full && rw && (a < 7'd5);
    if (wr_ok) mregs[a] = d;
    else if (!(full && !rw)) merr = (merr < 255) ? merr + 1 : 255;
    if (full && !rw) begin
      exp_rd = 8'h00;
      if (a < 7'd5) exp_rd = mregs[a];
      check("cipo_read", rd, exp_rd);
    end
    @(negedge clk);
    check("regs_out", regs_out, flat());
    check("err_count", err_count, merr);
    check("strobe_cycles", strobe_hi - s0, wr_ok ? 1 : 0);
    if (wr_ok) check("wr_addr", wr_addr, a);
    check("cipo_idle", CIPO, 1'b0);
  endtask

  initial begin
    logic [7:0] dummy;
    logic [15:0] w;
    rst = 1'b1; sCLK = 1'b0; nCS = 1'b1; COPI = 1'b0;
    for (int r = 0; r < 5; r++) mregs[r] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_regs", regs_out, 40'h0);
    check("rst_cipo", CIPO, 1'b0);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h0);
    check("rst_err", err_count, 8'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    frame(1'b1, 7'h04, 8'hC8, 16);
    check("reg4_c8", regs_out[39:32], 8'hC8);
    frame(1'b1, 7'h01, 8'hA5, 16);
    frame(1'b0, 7'h01, 8'h00, 16);
    frame(1'b0, 7'h7F, 8'h00, 16);
    frame(1'b1, 7'h05, 8'h55, 16);
    check("err_after_bad_wr", err_count, 8'd1);
    frame(1'b1, 7'h03, 8'h11, 10);
    frame(1'b1, 7'h03, 8'h22, 17);
    check("err_after_len", err_count, 8'd3);

    for (int k = 0; k < 40; k++) begin
      logic       rw;
      logic [6:0] a;
      int         n;
      rw = 1'($urandom);
      a  = ($urandom % 4 == 0) ? 7'($urandom) : 7'($urandom % 5);
      n  = ($urandom % 5 == 0) ? int'($urandom_range(0, 18)) : 16;
      frame(rw, a, 8'($urandom), n);
    end

    for (int k = 0; k < 260; k++) frame(1'b1, 7'h00, 8'h00, 1);
    check("err_saturated", err_count, 8'd255);

    // Reset in the middle of a write frame, then finish clocking with nCS still low
    w = {1'b1, 7'h03, 8'hFF};
    dummy = 8'h00;
    @(posedge clk);
    nCS = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++) send_bit(w[15-i], i, dummy);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 8; i < 16; i++) send_bit(w[15-i], i, dummy);
    repeat (8) @(posedge clk);
    nCS = 1'b1;
    repeat (12) @(posedge clk);
    for (int r = 0; r < 5; r++) mregs[r] = 8'h00;
    merr = 0;
    @(negedge clk);
    check("midrst_regs", regs_out, 40'h0);
    check("midrst_err", err_count, 8'd0);
    frame(1'b1, 7'h02, 8'h3C, 16);
    check("reg2_3c", regs_out, 40'h00_00_3C_00_00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
